// File: rtl/rbus_pkg.sv
// Shared rbus definitions: field widths, signal bit indices, the buffered
// beat format and arbitration defaults.
package rbus_pkg;

    localparam int rbus_width     = 16;
    localparam int RBUS_ADDR_W    = 37;
    localparam int RBUS_REQ_W     = 10;

    // Bit positions inside the signals field.
    localparam int rbus_second    = 15;
    localparam int rbus_used      = 14;

    localparam int STARVE_MAX_DEF = 19;
    localparam int STARVE_W       = 5;

    // One buffered beat: payload plus end-of-message marker.
    typedef struct packed {
        logic [rbus_width-1:0]  signals;
        logic [RBUS_REQ_W-1:0]  src;
        logic [RBUS_REQ_W-1:0]  dst;
        logic [RBUS_ADDR_W-1:0] addr;
        logic                   last;
    } rbus_beat_t;

    // Saturating increment for the starvation counters.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                    input logic [STARVE_W-1:0] lim);
        return (v >= lim) ? lim : v + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/rbus_arb_fifo.sv
// Small register FIFO of rbus beats. Ready is derived from the registered
// count only, so a full FIFO refuses a push even when it pops that cycle.
module rbus_arb_fifo
    import rbus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  rbus_beat_t din_i,
    output logic       full_o,
    output logic       empty_o,
    output rbus_beat_t head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rbus_beat_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rbus_inject_arb.sv
// Two-requester injection arbiter in front of one ring stop local input.
// Round-robin between A and B with a starvation override; a multi-beat
// message holds the grant until its last beat issues.
module rbus_inject_arb
    import rbus_pkg::*;
#(
    parameter int SIG_W      = rbus_width,
    parameter int ADDR_W     = RBUS_ADDR_W,
    parameter int REQ_W      = RBUS_REQ_W,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqA_valid,
    output logic              reqA_ready,
    input  logic [SIG_W-1:0]  reqA_signals,
    input  logic [REQ_W-1:0]  reqA_src,
    input  logic [REQ_W-1:0]  reqA_dst,
    input  logic [ADDR_W-1:0] reqA_addr,
    input  logic              reqA_last,
    input  logic              reqB_valid,
    output logic              reqB_ready,
    input  logic [SIG_W-1:0]  reqB_signals,
    input  logic [REQ_W-1:0]  reqB_src,
    input  logic [REQ_W-1:0]  reqB_dst,
    input  logic [ADDR_W-1:0] reqB_addr,
    input  logic              reqB_last,
    input  logic              stop_rdyIn,
    output logic              stop_valid,
    output logic [SIG_W-1:0]  stop_signals,
    output logic [REQ_W-1:0]  stop_src,
    output logic [REQ_W-1:0]  stop_dst,
    output logic [ADDR_W-1:0] stop_addr,
    output logic              gnt_owner,
    output logic              locked
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [1:0]               req_valid;
    logic [1:0]               fifo_full;
    logic [1:0]               fifo_empty;
    logic [1:0]               fifo_pop;
    logic [1:0]               starved;
    rbus_beat_t               req_beat [2];
    rbus_beat_t               fifo_head [2];
    rbus_beat_t               head_sel;

    logic                     lock_q, lock_d;
    logic                     lock_owner_q, lock_owner_d;
    logic                     rr_q, rr_d;
    logic                     gnt_q;
    logic [1:0][STARVE_W-1:0] starve_q, starve_d;
    logic                     grant;
    logic                     other;
    logic                     issue;

    assign req_valid   = {reqB_valid, reqA_valid};
    assign req_beat[0] = '{signals: reqA_signals, src: reqA_src, dst: reqA_dst,
                           addr: reqA_addr, last: reqA_last};
    assign req_beat[1] = '{signals: reqB_signals, src: reqB_src, dst: reqB_dst,
                           addr: reqB_addr, last: reqB_last};
    assign reqA_ready  = !fifo_full[0];
    assign reqB_ready  = !fifo_full[1];

    // Per-requester buffer, pop strobe and starvation flag (index 0 = A, 1 = B).
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        rbus_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (req_valid[gi]),
            .pop_i   (fifo_pop[gi]),
            .din_i   (req_beat[gi]),
            .full_o  (fifo_full[gi]),
            .empty_o (fifo_empty[gi]),
            .head_o  (fifo_head[gi])
        );
        assign starved[gi]  = (starve_q[gi] >= STARVE_LIM);
        assign fifo_pop[gi] = issue && (grant == 1'(gi));
    end

    // Grant decision from registered state; an empty lock owner gives a bubble.
    always_comb begin
        grant      = gnt_q;
        stop_valid = 1'b0;
        if (lock_q) begin
            grant      = lock_owner_q;
            stop_valid = !fifo_empty[lock_owner_q];
        end else if (!fifo_empty[0] && fifo_empty[1]) begin
            grant      = 1'b0;
            stop_valid = 1'b1;
        end else if (fifo_empty[0] && !fifo_empty[1]) begin
            grant      = 1'b1;
            stop_valid = 1'b1;
        end else if (!fifo_empty[0] && !fifo_empty[1]) begin
            stop_valid = 1'b1;
            if (starved[0] && !starved[1]) begin
                grant = 1'b0;
            end else if (starved[1] && !starved[0]) begin
                grant = 1'b1;
            end else begin
                grant = rr_q;
            end
        end
    end

    assign other        = ~grant;
    assign issue        = stop_valid && stop_rdyIn;
    assign head_sel     = fifo_head[grant];
    assign stop_signals = head_sel.signals;
    assign stop_src     = head_sel.src;
    assign stop_dst     = head_sel.dst;
    assign stop_addr    = head_sel.addr;
    assign gnt_owner    = grant;
    assign locked       = lock_q;

    // Lock, round-robin and starvation bookkeeping advance only on an issued beat.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        rr_d         = rr_q;
        starve_d     = starve_q;
        if (issue) begin
            if (head_sel.last) begin
                lock_d = 1'b0;
                rr_d   = other;
            end else begin
                lock_d       = 1'b1;
                lock_owner_d = grant;
            end
            starve_d[grant] = '0;
            if (!fifo_empty[other]) begin
                starve_d[other] = sat_inc(starve_q[other], STARVE_LIM);
            end
        end
    end

    // Arbiter state registers; the last grant is kept so gnt_owner holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            starve_q     <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rr_q         <= rr_d;
            gnt_q        <= grant;
            starve_q     <= starve_d;
        end
    end

endmodule
